// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage plus the IF/ID pipeline register. Word fetches go out
// to instruction memory, which may hold off with wait states (imem_ack low).
// A one-entry skid buffer absorbs a word that returns while decode is stalled.
// A taken branch from execute redirects the fetch PC.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   imem_req         fetch request (at most one outstanding)
//   imem_addr        word-aligned fetch address
//   imem_ack         memory returns imem_rdata this cycle (ignored unless imem_req)
//   imem_rdata       fetched instruction word
//   stall_d          hazard unit: hold IF/ID contents
//   flush_d          hazard unit: kill the IF/ID entry
//   branch_taken_e   execute-stage redirect
//   branch_target_e  redirect target (bits [1:0] forced to zero)
//   instr_d          decode-stage instruction
//   pc_plus8_d       address of instr_d + 8
//   valid_d          instr_d is a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_taken_e,
  input  logic [31:0] branch_target_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus8_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_BUFFERED = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_imem_req;

  // Skid buffer: holds one word that arrived while decode was stalled.
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  // IF/ID pipeline register.
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_plus8_d;
  logic        r_valid_d;

  logic        w_redirect;
  logic        w_accept;
  logic        w_load_mem;
  logic        w_load_skid;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus8;
  logic [31:0] w_skid_pc_plus8;
  logic        w_unused_target_lsbs;

  // A redirect is ignored in IDLE; everywhere else it beats any other event,
  // including a coincident ack, whose data is simply dropped.
  assign w_redirect  = branch_taken_e && (r_state != S_IDLE);

  // Fetched word is consumed this cycle (either into IF/ID or into the skid).
  assign w_accept    = (r_state == S_FETCH) && imem_ack && !w_redirect;
  assign w_load_mem  = w_accept && !stall_d;
  assign w_load_skid = (r_state == S_BUFFERED) && !stall_d && !w_redirect;

  assign w_target        = {branch_target_e[31:2], 2'b00};
  assign w_pc_plus4      = r_fetch_pc + 32'd4;
  assign w_pc_plus8      = r_fetch_pc + 32'd8;
  assign w_skid_pc_plus8 = r_skid_pc + 32'd8;

  // Target low bits are architecturally ignored.
  assign w_unused_target_lsbs = &branch_target_e[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_imem_req   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_instr_d    <= 32'd0;
      r_pc_plus8_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else begin
      // ---------------- fetch control ----------------
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end

        S_FETCH: begin
          if (w_redirect) begin
            r_fetch_pc   <= w_target;
            r_skid_valid <= 1'b0;
            r_imem_req   <= 1'b1;
          end else if (w_accept) begin
            r_fetch_pc <= w_pc_plus4;
            if (stall_d) begin
              // Decode cannot take the word: park it and stop requesting
              // until the skid drains.
              r_skid_valid <= 1'b1;
              r_skid_instr <= imem_rdata;
              r_skid_pc    <= r_fetch_pc;
              r_state      <= S_BUFFERED;
              r_imem_req   <= 1'b0;
            end
          end
        end

        S_BUFFERED: begin
          if (w_redirect) begin
            r_fetch_pc   <= w_target;
            r_skid_valid <= 1'b0;
            r_state      <= S_FETCH;
            r_imem_req   <= 1'b1;
          end else if (!stall_d) begin
            // fetch_pc already points past the parked word.
            r_skid_valid <= 1'b0;
            r_state      <= S_FETCH;
            r_imem_req   <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase

      // ---------------- IF/ID register ----------------
      // A new entry wins over a flush: the flush kills the old contents,
      // and the incoming word replaces them.
      if (w_load_mem) begin
        r_instr_d    <= imem_rdata;
        r_pc_plus8_d <= w_pc_plus8;
        r_valid_d    <= 1'b1;
      end else if (w_load_skid) begin
        r_instr_d    <= r_skid_instr;
        r_pc_plus8_d <= w_skid_pc_plus8;
        r_valid_d    <= 1'b1;
      end else if (flush_d) begin
        r_instr_d    <= 32'd0;
        r_pc_plus8_d <= 32'd0;
        r_valid_d    <= 1'b0;
      end
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_fetch_pc;
  assign instr_d    = r_instr_d;
  assign pc_plus8_d = r_pc_plus8_d;
  assign valid_d    = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage with directed scenarios followed by randomized traffic
// (stalls, flushes, redirects, wait states, resets) and compares every cycle
// against a transaction-level reference model: a next-PC variable, a queue of
// words waiting for decode, and the expected IF/ID contents.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        flush_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic [31:0] instr_d;
  logic [31:0] pc_plus8_d;
  logic        valid_d;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .branch_taken_e  (branch_taken_e),
    .branch_target_e (branch_target_e),
    .instr_d         (instr_d),
    .pc_plus8_d      (pc_plus8_d),
    .valid_d         (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int n_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } word_t;

  bit          m_started;   // first clock after reset release has happened
  logic [31:0] m_pc;        // next address to fetch
  word_t       m_pending[$]; // fetched but not yet handed to decode
  logic [31:0] m_instr;
  logic [31:0] m_pc8;
  logic        m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE000_0000;
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_pc      = RESET_PC;
    m_pending.delete();
    m_instr   = 32'd0;
    m_pc8     = 32'd0;
    m_valid   = 1'b0;
  endtask

  // One clock of stimulus: drive away from the edge, check the request side
  // before the edge and the IF/ID side after it.
  task automatic do_cycle(input bit stall, input bit flush, input bit br,
                          input logic [31:0] tgt, input bit ack);
    bit          m_req;
    bit          have_load;
    word_t       w;
    logic [31:0] req_addr;
    @(negedge clk);
    m_req           = m_started && (m_pending.size() == 0);
    req_addr        = m_pc;
    stall_d         = stall;
    flush_d         = flush;
    branch_taken_e  = br;
    branch_target_e = tgt;
    imem_ack        = ack;
    imem_rdata      = m_req ? mem_word(m_pc) : $urandom;
    #1;
    check_val("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    if (m_req) check_val("imem_addr", imem_addr, req_addr);

    @(posedge clk);
    have_load = 1'b0;
    w.instr   = 32'd0;
    w.pc      = 32'd0;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (br) begin
      m_pc = {tgt[31:2], 2'b00};
      m_pending.delete();
    end else if (m_pending.size() > 0) begin
      if (!stall) begin
        w = m_pending.pop_front();
        have_load = 1'b1;
      end
    end else if (ack) begin
      w.instr = mem_word(m_pc);
      w.pc    = m_pc;
      if (stall) m_pending.push_back(w);
      else       have_load = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    if (have_load) begin
      m_instr = w.instr;
      m_pc8   = w.pc + 32'd8;
      m_valid = 1'b1;
    end else if (flush) begin
      m_instr = 32'd0;
      m_pc8   = 32'd0;
      m_valid = 1'b0;
    end
    #1;
    n_cyc++;
    $display("cyc %0d st=%b fl=%b br=%b tgt=%h ack=%b req=%b addr=%h | instr_d=%h pc8=%h v=%b",
             n_cyc, stall, flush, br, tgt, ack, m_req, req_addr, instr_d, pc_plus8_d, valid_d);
    check_val("instr_d", instr_d, m_instr);
    check_val("pc_plus8_d", pc_plus8_d, m_pc8);
    check_val("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
  endtask

  // Assert reset partway through a cycle, check outputs clear at once, then
  // release it so the next rising edge is the first one out of reset.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    #1;
    check_val("rst_instr_d", instr_d, 32'd0);
    check_val("rst_pc_plus8_d", pc_plus8_d, 32'd0);
    check_val("rst_valid_d", {31'd0, valid_d}, 32'd0);
    check_val("rst_imem_req", {31'd0, imem_req}, 32'd0);
    model_reset();
    @(posedge clk);
    #3;
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    $display("reset applied and released");
  endtask

  initial begin
    bit          r_st, r_fl, r_br, r_ack;
    logic [31:0] r_tgt;
    n_vec = 0;
    n_bad = 0;
    n_cyc = 0;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    branch_taken_e = 1'b0;
    branch_target_e = 32'd0;
    model_reset();
    #12;
    do_reset();

    // Zero-wait memory: first cycle leaves IDLE, then one word per cycle.
    repeat (4) do_cycle(0, 0, 0, 32'd0, 1);
    // Two wait states per fetch.
    repeat (2) begin
      do_cycle(0, 0, 0, 32'd0, 0);
      do_cycle(0, 0, 0, 32'd0, 0);
      do_cycle(0, 0, 0, 32'd0, 1);
    end
    // Ack while stalled -> skid, stay stalled, then release.
    do_cycle(1, 0, 0, 32'd0, 1);
    do_cycle(1, 0, 0, 32'd0, 0);
    do_cycle(1, 0, 0, 32'd0, 0);
    do_cycle(0, 0, 0, 32'd0, 0);
    do_cycle(0, 0, 0, 32'd0, 1);
    // Redirect with coincident ack and flush.
    do_cycle(0, 1, 1, 32'h0000_0102, 1);
    do_cycle(0, 0, 0, 32'd0, 1);
    do_cycle(0, 0, 0, 32'd0, 1);
    // Flush with coincident accepted ack: new entry wins.
    do_cycle(0, 1, 0, 32'd0, 1);
    // Redirect while BUFFERED and stalled: parked word must never appear.
    do_cycle(1, 0, 0, 32'd0, 1);
    do_cycle(1, 1, 1, 32'h0000_0200, 0);
    do_cycle(0, 0, 0, 32'd0, 1);
    do_cycle(0, 0, 0, 32'd0, 1);
    // Wrap at the top of the address space, then reset mid-wait.
    do_cycle(0, 1, 1, 32'hFFFF_FFFD, 0);
    do_cycle(0, 0, 0, 32'd0, 1);
    do_cycle(0, 0, 0, 32'd0, 0);
    do_reset();
    repeat (3) do_cycle(0, 0, 0, 32'd0, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      r_st  = ($urandom_range(0, 3) == 0);
      r_br  = ($urandom_range(0, 19) == 0);
      r_fl  = r_br ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      r_ack = ($urandom_range(0, 9) < 6);
      r_tgt = $urandom;
      if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF0 | (r_tgt & 32'hF);
      do_cycle(r_st, r_fl, r_br, r_tgt, r_ack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
